// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: ingest FSM states,
// register bit positions seen by firmware, and the break character.
package uart_rx_fifo_pkg;

  // Two-state ingest handshake with the buart holding register
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ingest_state_t;

  // Data register layout: head byte in [7:0], then status flags above it
  localparam int DAT_NEMPTY = 8;
  localparam int DAT_OVF    = 9;

  // Control/status register layout: level in [15:8], flags in the low nibble
  localparam int STAT_NEMPTY  = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_LVL_MSB = 15;

  // Control register write bits
  localparam int CTL_FLUSH   = 0;
  localparam int CTL_CLR_OVF = 1;

  // ctrl-C: ingesting this byte raises the break pulse
  localparam logic [7:0] BRK_CHAR = 8'h03;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage for the receive FIFO. One synchronous write port and
// one asynchronous read port so the head byte falls through without latency.
// The array carries no reset; validity is tracked by the pointers outside.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Store the incoming byte at the write pointer
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the buart receiver and the CPU I/O bus.
// Drains buart's single-byte holding register into a FIFO, exposes a
// pop-on-read data register and a control/status register, tracks a
// sticky overflow flag and pulses brk when a ctrl-C byte is ingested.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        uart_valid,
  input  logic [7:0]  uart_data,
  output logic        uart_rd,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel_dat,
  input  logic        sel_cntl,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        brk
);

  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  ingest_state_t r_state;
  logic          r_uartRd;
  logic          r_brkHit;
  logic          r_brk;

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic          w_full;
  logic          w_nempty;
  logic          w_flush;
  logic          w_clrOvf;
  logic          w_pushReq;
  logic          w_popReq;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [AW:0]   w_levelNext;
  logic [7:0]    w_memRdata;
  logic [7:0]    w_head;
  logic [7:0]    w_level8;
  logic [31:0]   w_rdata;
  logic          w_unusedWdata;

  assign w_full   = (r_level == LVL_DEPTH);
  assign w_nempty = (r_level != '0);

  // Bus-side control decode; flush overrides every other FIFO event
  assign w_flush  = sel_cntl && wstrb && wdata[CTL_FLUSH];
  assign w_clrOvf = sel_cntl && wstrb && wdata[CTL_CLR_OVF];

  // A new byte is only taken in IDLE, so the stale valid seen during ACK is ignored
  assign w_pushReq = (r_state == ST_IDLE) && uart_valid;
  assign w_popReq  = sel_dat && rstrb && w_nempty;

  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_pop  = w_popReq && !w_flush;
  assign w_push = w_pushReq && !w_flush && (!w_full || w_pop);
  assign w_drop = w_pushReq && !w_flush && w_full && !w_pop;

  // Only the two control bits of the write data are meaningful
  assign w_unusedWdata = ^wdata[31:2];

  // Ingest handshake: acknowledge buart one cycle, then give it a cycle to drop valid
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state  <= ST_IDLE;
      r_uartRd <= 1'b0;
      r_brkHit <= 1'b0;
      r_brk    <= 1'b0;
    end else begin
      r_brk <= r_brkHit;
      case (r_state)
        ST_IDLE: begin
          if (uart_valid) begin
            r_state  <= ST_ACK;
            r_uartRd <= 1'b1;
            r_brkHit <= (uart_data == BRK_CHAR);
          end else begin
            r_uartRd <= 1'b0;
            r_brkHit <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state  <= ST_IDLE;
          r_uartRd <= 1'b0;
          r_brkHit <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_uartRd <= 1'b0;
          r_brkHit <= 1'b0;
        end
      endcase
    end
  end

  assign uart_rd = r_uartRd;
  assign brk     = r_brk;

  // Occupancy after this cycle's push and pop
  always_comb begin
    w_levelNext = r_level;
    case ({w_push, w_pop})
      2'b10:   w_levelNext = r_level + LVL_ONE;
      2'b01:   w_levelNext = r_level - LVL_ONE;
      default: w_levelNext = r_level;
    endcase
  end

  // Pointer and level bookkeeping; pointers wrap naturally at AW bits
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_level <= w_levelNext;
    end
  end

  // Sticky overflow: set by a dropped byte, cleared by flush or an explicit clear
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_clrOvf) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (uart_data),
    .i_raddr (r_rdPtr),
    .o_rdata (w_memRdata)
  );

  assign w_head   = w_nempty ? w_memRdata : 8'h00;
  assign w_level8 = 8'(r_level);

  // Bus read mux; the data register wins when both selects are active
  always_comb begin
    w_rdata = '0;
    if (sel_dat) begin
      w_rdata[7:0]       = w_head;
      w_rdata[DAT_NEMPTY] = w_nempty;
      w_rdata[DAT_OVF]    = r_overflow;
    end else if (sel_cntl) begin
      w_rdata[STAT_LVL_MSB:STAT_LVL_LSB] = w_level8;
      w_rdata[STAT_OVF]    = r_overflow;
      w_rdata[STAT_FULL]   = w_full;
      w_rdata[STAT_NEMPTY] = w_nempty;
    end
  end

  assign rdata = w_rdata;

endmodule
